alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 119 +++++++++++
 tb/tb_alu_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// alu_sequencer: Moore controller that sequences operand reads, one ALU operation and the
// register write-back for a single command. Rev 1.0
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [1:0] op,
  input  logic [2:0] rd,
  input  logic [2:0] rn,
  input  logic [2:0] rm,
  output logic       w,
  output logic [2:0] readnum,
  output logic [2:0] writenum,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic [1:0] ALUop,
  output logic       done
);

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4
  } state_t;

  // Kept as a raw vector so the three unused encodings remain representable and recoverable.
  logic [2:0] r_state;
  logic [1:0] r_op;
  logic [2:0] r_rd;
  logic [2:0] r_rn;
  logic [2:0] r_rm;

  assign ALUop = r_op;

  // Outputs are registered alongside the state: each branch loads the values for the state it enters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= WAIT;
      r_op     <= 2'b00;
      r_rd     <= 3'd0;
      r_rn     <= 3'd0;
      r_rm     <= 3'd0;
      w        <= 1'b1;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      done     <= 1'b0;
    end else begin
      w        <= 1'b0;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        WAIT: begin
          if (s) begin
            r_op <= op;
            r_rd <= rd;
            r_rn <= rn;
            r_rm <= rm;
            // NOT-B has no A operand, so the A read is skipped.
            if (op == 2'b11) begin
              r_state <= LOADB;
              loadb   <= 1'b1;
              readnum <= rm;
            end else begin
              r_state <= LOADA;
              loada   <= 1'b1;
              readnum <= rn;
            end
          end else begin
            r_state <= WAIT;
            w       <= 1'b1;
          end
        end
        LOADA: begin
          r_state <= LOADB;
          loadb   <= 1'b1;
          readnum <= r_rm;
        end
        LOADB: begin
          r_state <= EXEC;
          loadc   <= 1'b1;
          loads   <= 1'b1;
        end
        EXEC: begin
          r_state  <= WRITE;
          write    <= 1'b1;
          writenum <= r_rd;
        end
        WRITE: begin
          r_state <= WAIT;
          w       <= 1'b1;
          done    <= 1'b1;
        end
        default: begin
          r_state <= WAIT;
          w       <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// tb_alu_sequencer: table-driven scoreboard bench for alu_sequencer. Rev 1.0
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] rd = 3'd0;
  logic [2:0] rn = 3'd0;
  logic [2:0] rm = 3'd0;
  logic       w, write, loada, loadb, loadc, loads, done;
  logic [2:0] readnum, writenum;
  logic [1:0] ALUop;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .s(s), .op(op), .rd(rd), .rn(rn), .rm(rm),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .ALUop(ALUop), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic [1:0] aluop;
    logic       done;
  } outs_t;

  typedef struct {
    logic [1:0] op;
    logic [2:0] rd;
    logic [2:0] rn;
    logic [2:0] rm;
    int         write_cyc;
    int         done_cyc;
  } vec_t;

  outs_t      q[$];
  vec_t       vecs[6];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] last_op = 2'b00;

  // stage 0 idle, 1 LOADA, 2 LOADB, 3 EXEC, 4 WRITE, 5 done cycle
  function automatic outs_t mk(int stage, logic [1:0] o_op, logic [2:0] o_rd,
                               logic [2:0] o_rn, logic [2:0] o_rm);
    outs_t o;
    o = '0;
    o.aluop = o_op;
    case (stage)
      0: o.w = 1'b1;
      1: begin o.loada = 1'b1; o.readnum = o_rn; end
      2: begin o.loadb = 1'b1; o.readnum = o_rm; end
      3: begin o.loadc = 1'b1; o.loads = 1'b1; end
      4: begin o.write = 1'b1; o.writenum = o_rd; end
      default: begin o.w = 1'b1; o.done = 1'b1; end
    endcase
    return o;
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("w=%b rdn=%0d wrn=%0d wr=%b la=%b lb=%b lc=%b ls=%b aluop=%0d done=%b",
                     o.w, o.readnum, o.writenum, o.write, o.loada, o.loadb, o.loadc,
                     o.loads, o.aluop, o.done);
  endfunction

  task automatic check(input string nm, input outs_t exp);
    outs_t act;
    act = {w, readnum, writenum, write, loada, loadb, loadc, loads, ALUop, done};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got [%s] want [%s]", nm, fmt(act), fmt(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; optionally pulse s with a conflicting command during cycle 'inject'.
  task automatic run_vec(input vec_t v, input int inject, input string tag);
    for (int c = 1; c <= v.done_cyc; c++)
      q.push_back(mk(c + 4 - v.write_cyc, v.op, v.rd, v.rn, v.rm));
    s = 1'b1; op = v.op; rd = v.rd; rn = v.rn; rm = v.rm;
    step();
    s  = 1'b0;
    op = 2'($urandom_range(0, 3));
    rd = 3'($urandom_range(0, 7));
    rn = 3'($urandom_range(0, 7));
    rm = 3'($urandom_range(0, 7));
    for (int c = 1; c <= v.done_cyc; c++) begin
      check($sformatf("%s cyc%0d", tag, c), q.pop_front());
      if (c == inject) begin
        s = 1'b1; op = 2'b10; rd = 3'd7;
      end else begin
        s = 1'b0;
      end
      if (c < v.done_cyc) step();
    end
    last_op = v.op;
  endtask

  initial begin
    vecs[0] = '{2'b00, 3'd3, 3'd1, 3'd2, 4, 5};
    vecs[1] = '{2'b11, 3'd6, 3'd0, 3'd5, 3, 4};
    vecs[2] = '{2'b01, 3'd4, 3'd5, 3'd6, 4, 5};
    vecs[3] = '{2'b10, 3'd7, 3'd0, 3'd1, 4, 5};
    vecs[4] = '{2'b11, 3'd1, 3'd7, 3'd3, 3, 4};
    vecs[5] = '{2'b00, 3'd0, 3'd7, 3'd7, 4, 5};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset idle", mk(0, 2'b00, 3'd0, 3'd0, 3'd0));
    reset = 1'b0;
    step();
    check("post-reset idle", mk(0, 2'b00, 3'd0, 3'd0, 3'd0));

    // Back-to-back commands, each accepted in the previous command's done cycle
    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], 0, $sformatf("vec%0d", i));
    step();
    check("idle after table", mk(0, last_op, 3'd0, 3'd0, 3'd0));

    // s pulsed during LOADB must be ignored
    run_vec(vecs[0], 2, "ignore_s");
    step();
    check("no second cmd", mk(0, 2'b00, 3'd0, 3'd0, 3'd0));
    step();
    check("no second cmd 2", mk(0, 2'b00, 3'd0, 3'd0, 3'd0));

    // Reset during EXEC abandons the command
    s = 1'b1; op = 2'b01; rd = 3'd5; rn = 3'd1; rm = 3'd2;
    step();
    s = 1'b0;
    check("rst_exec cyc1", mk(1, 2'b01, 3'd5, 3'd1, 3'd2));
    step();
    check("rst_exec cyc2", mk(2, 2'b01, 3'd5, 3'd1, 3'd2));
    step();
    check("rst_exec cyc3", mk(3, 2'b01, 3'd5, 3'd1, 3'd2));
    #2 reset = 1'b1;
    #1 check("rst_exec async", mk(0, 2'b00, 3'd0, 3'd0, 3'd0));
    step();
    check("rst_exec held", mk(0, 2'b00, 3'd0, 3'd0, 3'd0));
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check($sformatf("rst_exec quiet%0d", c), mk(0, 2'b00, 3'd0, 3'd0, 3'd0));
    end

    // s held high: one accept per 5 cycles, done coinciding with each re-accept
    for (int k = 0; k < 3; k++)
      for (int c = 1; c <= 5; c++)
        q.push_back(mk(c, 2'b01, 3'd2, 3'd3, 3'd4));
    s = 1'b1; op = 2'b01; rd = 3'd2; rn = 3'd3; rm = 3'd4;
    step();
    for (int c = 1; c <= 15; c++) begin
      check($sformatf("stream cyc%0d", c), q.pop_front());
      if (c == 15) s = 1'b0;
      step();
    end
    check("stream stop", mk(0, 2'b01, 3'd0, 3'd0, 3'd0));
    last_op = 2'b01;

    // Illegal state encoding recovers to WAIT after one edge
    force dut.r_state = 3'b110;
    step();
    check("illegal one edge", mk(0, last_op, 3'd0, 3'd0, 3'd0));
    release dut.r_state;
    step();
    step();
    check("illegal recovered", mk(0, last_op, 3'd0, 3'd0, 3'd0));
    run_vec(vecs[1], 0, "after_illegal");

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
